// File: rtl/store_unit_pkg.sv
// Shared store-unit types: access widths, controller states and per-width byte masks.
package store_unit_pkg;

  typedef enum logic [1:0] {
    SW_BYTE = 2'd0,
    SW_HALF = 2'd1,
    SW_WORD = 2'd2,
    SW_RSVD = 2'd3
  } store_width_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } store_controller_state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Reserved width yields an empty mask so it can never produce a strobe.
  function automatic logic [3:0] width_mask(input store_width_t w);
    case (w)
      SW_BYTE: width_mask = MASK_BYTE;
      SW_HALF: width_mask = MASK_HALF;
      SW_WORD: width_mask = MASK_WORD;
      default: width_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_aligner.sv
// Positions a right-justified store onto 32-bit bus lanes; beat 1 carries the
// bytes that spill past the first word of a misaligned store.
module store_lane_aligner
  import store_unit_pkg::*;
(
  input  logic [31:0]  data_i,
  input  logic [1:0]   offset_i,
  input  store_width_t width_i,
  input  logic         beat_i,
  output logic [3:0]   strobe_o,
  output logic [31:0]  data_o,
  output logic         split_o
);

  logic [7:0]  mask_sh;
  logic [63:0] data_sh;

  // Shift across a double-width window: the upper half is exactly beat 1.
  assign mask_sh  = {4'b0000, width_mask(width_i)} << offset_i;
  assign data_sh  = {32'h0, data_i} << {offset_i, 3'b000};
  assign split_o  = |mask_sh[7:4];
  assign strobe_o = beat_i ? mask_sh[7:4]    : mask_sh[3:0];
  assign data_o   = beat_i ? data_sh[63:32]  : data_sh[31:0];

endmodule

// File: rtl/store_bus_controller.sv
// Drains one committed store per request into one or two word-aligned bus
// write beats, with ack timeout, and reports a single-cycle done/error.
module store_bus_controller
  import store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         store_request_i,
  input  logic [31:0]  store_address_i,
  input  logic [31:0]  store_data_i,
  input  store_width_t store_width_i,
  output logic         store_done_o,
  output logic         store_error_o,
  output logic         bus_valid_o,
  output logic [31:0]  bus_address_o,
  output logic [31:0]  bus_data_o,
  output logic [3:0]   bus_strobe_o,
  input  logic         bus_ack_i,
  input  logic         bus_error_i,
  output logic         busy_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  store_controller_state_t state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  store_width_t width_q, width_d;
  logic         err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        beat_active, in_beat1, split, timeout_hit;
  logic [3:0]  lane_strobe;
  logic [31:0] lane_data;

  assign beat_active = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign in_beat1    = (state_q == ST_BEAT1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (32'(cnt_q) + 32'd1 >= 32'(TIMEOUT_CYCLES));

  store_lane_aligner u_aligner (
    .data_i   (data_q),
    .offset_i (addr_q[1:0]),
    .width_i  (width_q),
    .beat_i   (in_beat1),
    .strobe_o (lane_strobe),
    .data_o   (lane_data),
    .split_o  (split)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    width_d = width_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (store_request_i) begin
          addr_d  = store_address_i;
          data_d  = store_data_i;
          width_d = store_width_i;
          cnt_d   = '0;
          err_d   = (store_width_i == SW_RSVD);
          state_d = (store_width_i == SW_RSVD) ? ST_DONE : ST_BEAT0;
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (bus_ack_i) begin
          cnt_d = '0;
          if (bus_error_i) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (!in_beat1 && split) begin
            state_d = ST_BEAT1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      width_q <= SW_BYTE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      width_q <= width_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus fields are zero whenever no beat is being presented.
  assign bus_valid_o   = beat_active;
  assign bus_address_o = beat_active ? ({addr_q[31:2], 2'b00} + (in_beat1 ? 32'd4 : 32'd0)) : 32'h0;
  assign bus_strobe_o  = beat_active ? lane_strobe : 4'h0;
  assign bus_data_o    = beat_active ? lane_data : 32'h0;
  assign store_done_o  = (state_q == ST_DONE);
  assign store_error_o = (state_q == ST_DONE) && err_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_store_bus_controller.sv
// Randomized and directed checks of store_bus_controller against a byte-level
// reference model (each data byte i lands at address+i).
module tb_store_bus_controller;
  import store_unit_pkg::*;

  localparam int TO = 4;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         store_request_i;
  logic [31:0]  store_address_i;
  logic [31:0]  store_data_i;
  store_width_t store_width_i;
  logic         store_done_o, store_error_o, bus_valid_o, busy_o;
  logic [31:0]  bus_address_o, bus_data_o;
  logic [3:0]   bus_strobe_o;
  logic         bus_ack_i, bus_error_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_strb [2];
  int          exp_nb;

  always #5 clk_i = ~clk_i;

  store_bus_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .store_request_i (store_request_i),
    .store_address_i (store_address_i),
    .store_data_i    (store_data_i),
    .store_width_i   (store_width_i),
    .store_done_o    (store_done_o),
    .store_error_o   (store_error_o),
    .bus_valid_o     (bus_valid_o),
    .bus_address_o   (bus_address_o),
    .bus_data_o      (bus_data_o),
    .bus_strobe_o    (bus_strobe_o),
    .bus_ack_i       (bus_ack_i),
    .bus_error_i     (bus_error_i),
    .busy_o          (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Byte-level model: data byte i goes to address a+i; bytes below the width are strobed.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    int n;
    logic [31:0] ba;
    int beat;
    n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
    exp_addr[0] = a & 32'hFFFF_FFFC;
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_data[0] = '0; exp_data[1] = '0;
    exp_strb[0] = '0; exp_strb[1] = '0;
    for (int i = 0; i < 4; i++) begin
      ba   = a + 32'(i);
      beat = ((ba & 32'hFFFF_FFFC) != exp_addr[0]) ? 1 : 0;
      exp_data[beat][8*ba[1:0] +: 8] = d[8*i +: 8];
      if (i < n) exp_strb[beat][ba[1:0]] = 1'b1;
    end
    exp_nb = (n == 0) ? 0 : (exp_strb[1] != 4'h0) ? 2 : 1;
  endtask

  // Starts and ends at a negedge with the DUT idle. dl[b] = cycles before ack
  // on beat b (>= TO means the beat times out), er[b] = error with that ack.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                           input int dl0, input int dl1, input bit er0, input bit er1);
    int dl [2];
    bit er [2];
    bit exp_err, stop;
    dl[0] = dl0; dl[1] = dl1; er[0] = er0; er[1] = er1;
    model(a, d, w);
    exp_err = (exp_nb == 0);
    stop = 0;
    store_request_i = 1'b1;
    store_address_i = a;
    store_data_i    = d;
    store_width_i   = store_width_t'(w);
    @(negedge clk_i);
    store_request_i = 1'b0;
    for (int b = 0; b < exp_nb && !stop; b++) begin
      for (int c = 0; ; c++) begin
        chk("valid", 32'(bus_valid_o), 32'd1);
        chk("addr", bus_address_o, exp_addr[b]);
        chk("strobe", 32'(bus_strobe_o), 32'(exp_strb[b]));
        chk("data", bus_data_o, exp_data[b]);
        chk("done_in_beat", 32'(store_done_o), 32'd0);
        if (c == dl[b]) begin
          bus_ack_i = 1'b1;
          bus_error_i = er[b];
          @(negedge clk_i);
          bus_ack_i = 1'b0;
          bus_error_i = 1'b0;
          if (er[b]) begin exp_err = 1; stop = 1; end
          break;
        end else if (c == TO - 1) begin
          bus_error_i = 1'($urandom);
          @(negedge clk_i);
          bus_error_i = 1'b0;
          exp_err = 1; stop = 1;
          break;
        end else begin
          bus_error_i = 1'($urandom);
          @(negedge clk_i);
        end
      end
    end
    chk("done", 32'(store_done_o), 32'd1);
    chk("error", 32'(store_error_o), 32'(exp_err));
    chk("valid_at_done", 32'(bus_valid_o), 32'd0);
    chk("addr_at_done", bus_address_o, 32'd0);
    @(negedge clk_i);
    chk("done_pulse_end", 32'(store_done_o), 32'd0);
    chk("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    store_request_i = 1'b0;
    store_address_i = '0;
    store_data_i = '0;
    store_width_i = SW_BYTE;
    bus_ack_i = 1'b0;
    bus_error_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(bus_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(store_done_o), 32'd0);
    chk("rst_addr", bus_address_o, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Directed cases
    run_store(32'h0000_1000, 32'hAABB_CCDD, 2'd2, 0, 0, 0, 0);
    run_store(32'h0000_2003, 32'h0000_00EE, 2'd0, 1, 0, 0, 0);
    run_store(32'h0000_1001, 32'hAABB_CCDD, 2'd2, 0, 2, 0, 0);
    run_store(32'h0000_3003, 32'h0000_1234, 2'd1, 2, 0, 0, 0);
    run_store(32'h0000_1002, 32'h1122_3344, 2'd2, 0, 0, 1, 0);
    run_store(32'hFFFF_FFFD, 32'hCAFE_F00D, 2'd2, 0, 0, 0, 0);
    run_store(32'h0000_4000, 32'h5555_AAAA, 2'd2, 9, 0, 0, 0);
    run_store(32'h0000_4004, 32'h0102_0304, 2'd2, 3, 0, 0, 0);
    run_store(32'h0000_5002, 32'h0000_BEEF, 2'd3, 0, 0, 0, 0);
    run_store(32'h0000_5003, 32'hDEAD_BEEF, 2'd1, 0, 9, 0, 0);
    run_store(32'h0000_5001, 32'h0000_7766, 2'd1, 0, 0, 0, 1);

    // Reset asserted while the second beat is pending
    store_request_i = 1'b1;
    store_address_i = 32'h0000_6002;
    store_data_i    = 32'h8899_AABB;
    store_width_i   = SW_WORD;
    @(negedge clk_i);
    store_request_i = 1'b0;
    bus_ack_i = 1'b1;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("beat1_before_rst", bus_address_o, 32'h0000_6004);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_valid_o), 32'd0);
    chk("arst_addr", bus_address_o, 32'd0);
    chk("arst_data", bus_data_o, 32'd0);
    chk("arst_strobe", 32'(bus_strobe_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("arst_no_done", 32'(store_done_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_no_done", 32'(store_done_o), 32'd0);
    run_store(32'h0000_7000, 32'h0BAD_F00D, 2'd2, 0, 0, 0, 0);

    // Randomized traffic, including timeouts, bus errors and reserved widths
    for (int k = 0; k < 300; k++) begin
      logic [1:0] w;
      w = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_store($urandom, $urandom, w, $urandom_range(0, 5), $urandom_range(0, 5),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/store_bus_controller.md
# store_bus_controller

Downstream consumer of the store buffer's pull channel. Latches one committed store per request, converts it into one or two word-aligned bus write beats with byte strobes (a misaligned half/word store is split across two words), waits for bus acknowledge with a timeout, then returns a single-cycle done (with error flag) so the buffer advances its pull pointer.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 64: max cycles a beat may wait for ack; 0 disables timeout.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- store_request_i  in  1  pull request from store buffer; single-cycle pulse.
- store_address_i  in  32  byte address; stable from request until done.
- store_data_i  in  32  store data, right-justified (LSB = byte at address).
- store_width_i  in  store_width_t (2)  BYTE=0, HALF=1, WORD=2; 3 reserved.
- store_done_o  out  1  one-cycle pulse: store finished (or aborted).
- store_error_o  out  1  valid with store_done_o: bus error, timeout or reserved width.
- bus_valid_o  out  1  write beat valid; held until bus_ack_i.
- bus_address_o  out  32  word-aligned address ([1:0]=0).
- bus_data_o  out  32  lane-positioned write data.
- bus_strobe_o  out  4  byte enables.
- bus_ack_i  in  1  beat accepted/completed; sampled only while bus_valid_o=1.
- bus_error_i  in  1  qualifies bus_ack_i; beat failed.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: on store_request_i latch address, data, width; compute offset = address[1:0], mask = 0001/0011/1111 for BYTE/HALF/WORD; split = (mask << offset) exceeds bit 3. Reserved width -> DONE with error, no bus beat. Else -> BEAT0.
- BEAT0: bus_address_o = {addr[31:2],2'b00}; bus_strobe_o = (mask << offset)[3:0]; bus_data_o = (data << 8*offset)[31:0]. On ack: error -> DONE(error); else split -> BEAT1, else DONE.
- BEAT1: bus_address_o = BEAT0 address + 4 (wraps at 2^32); bus_strobe_o = mask >> (4-offset); bus_data_o = data >> 8*(4-offset). On ack -> DONE, error = bus_error_i.
- DONE: store_done_o=1, store_error_o = sticky error; -> IDLE.
- Timeout: counter cleared on entering each beat, increments each beat cycle without ack; when TIMEOUT_CYCLES reached without ack: drop valid, -> DONE with error, remaining beat skipped.
- store_request_i outside IDLE ignored (buffer never issues it before done).
- Inactive outputs (valid=0) drive address/data/strobe to 0.

## Timing
- Reset (async): state IDLE; bus_valid_o, bus_address_o, bus_data_o, bus_strobe_o, store_done_o, store_error_o, busy_o all 0; error and timeout counter cleared.
- All outputs registered / decoded from registered state; no combinational path from bus_ack_i to bus outputs or store_done_o.
- Request sampled at edge N -> bus_valid_o high from cycle N+1. Ack sampled at edge M (single beat) -> store_done_o high in cycle M+1 for exactly one cycle. Ack same cycle valid rises: 1-beat store completes in 3 cycles (request, beat, done).
- Split store: BEAT1 valid in cycle after BEAT0 ack; one bubble-free transition.
- Back-to-back: new request accepted in IDLE the cycle after DONE.
- Reset mid-beat: valid drops immediately, no done pulse issued.

## Structure
- Add to store_unit_pkg: store_controller_state_t enum (IDLE, BEAT0, BEAT1, DONE); byte-mask constants per store_width_t.
- One combinational sub-module natural: store_lane_aligner (inputs data, offset, width, beat select; outputs strobe, data, split flag).
- Top: FSM, capture registers, timeout counter ($clog2(TIMEOUT_CYCLES+1) bits).

## Test plan
- Aligned word 0xAABBCCDD @0x1000, ack immediate -> one beat addr 0x1000 strobe 1111 data 0xAABBCCDD; done one cycle after ack, error 0.
- Byte 0x000000EE @0x2003 -> addr 0x2000 strobe 1000 data 0xEE000000; single beat.
- Misaligned word 0xAABBCCDD @0x1001 -> beat0 0x1000/1110/0xBBCCDD00, beat1 0x1004/0001/0x000000AA; one done pulse after second ack. Half 0x1234 @0x3003 -> 0x3000/1000/0x34000000 then 0x3004/0001/0x00000012.
- Bus error on beat0 of split store -> no beat1, done with error=1. Address 0xFFFFFFFD word -> beat1 addr 0x00000000.
- TIMEOUT_CYCLES=4, ack withheld -> valid high 4 cycles, drops, done with error=1; later store completes normally.
- rst_n_i asserted mid-BEAT1 -> all outputs 0 asynchronously, no done; post-reset request handled normally; reserved width 3 -> done+error, no bus_valid_o.
